// File: rtl/delay_pkg.sv
// delay_pkg: shared types and default sizes for the delay-line sequencer.
//   state_t               - sequencer state (PRIME while filling, RUN once primed)
//   DEF_ADDRESS_WIDTH     - default RAM address width (buffer depth 2**width)
//   DEF_DATA_WIDTH        - default sample width
package delay_pkg;

    localparam int DEF_ADDRESS_WIDTH = 9;
    localparam int DEF_DATA_WIDTH    = 8;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/delay_line.sv
// delay_line: programmable delay line = delay_ctrl sequencer plus the
// dual-port sample RAM (one synchronous write port, one synchronous
// registered read port).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (sequencer only)
//   en           sample strobe
//   delay        delay in samples
//   din          input sample
//   dout         delayed sample
//   dout_valid   dout valid, one cycle after each strobe
module delay_line
    import delay_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid
);

    logic                     primed;
    logic                     ram_wr_en;
    logic                     ram_rd_en;
    logic [ADDRESS_WIDTH-1:0] ram_wr_addr;
    logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0]    ram_din;
    logic [DATA_WIDTH-1:0]    ram_dout;

    logic [DATA_WIDTH-1:0]    mem [2**ADDRESS_WIDTH];

    delay_ctrl #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .delay       (delay),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .primed      (primed),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_en   (ram_rd_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_addr (ram_rd_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Block RAM: no reset on the array or read register. Reads only happen
    // in RUN (ram_rd_en already implies it; primed is a cheap guard).
    always_ff @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_din;
        end
        if (ram_rd_en && primed) begin
            ram_dout <= mem[ram_rd_addr];
        end
    end

endmodule

// File: rtl/delay_ctrl.sv
// delay_ctrl: address sequencer that turns a dual-port sample RAM into a
// programmable circular delay line. Every strobe writes the incoming sample at
// a rolling write pointer and (once primed) reads back the sample written
// `delay` strobes earlier. Output latency is one cycle for every strobe.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              sample strobe
//   delay           requested delay in samples (0 .. 2**ADDRESS_WIDTH-1)
//   din             input sample, qualified by en
//   dout            delayed sample (0 while priming)
//   dout_valid      dout is valid this cycle (en delayed by one cycle)
//   primed          high while in RUN
//   ram_wr_en/ram_wr_addr/ram_din   RAM write port
//   ram_rd_en/ram_rd_addr           RAM read port
//   ram_dout        RAM read data, valid the cycle after ram_rd_en
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic                     primed,
    output logic                     ram_wr_en,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] fill;
    logic [ADDRESS_WIDTH-1:0] fill_next;
    logic [ADDRESS_WIDTH-1:0] delay_q;
    logic                     sel_q;
    logic [DATA_WIDTH-1:0]    byp_q;

    logic                     delay_change;
    logic                     rd_go;
    logic                     byp_load;
    logic [ADDRESS_WIDTH:0]   fill_ext;
    logic [ADDRESS_WIDTH:0]   fill_inc_ext;
    logic [ADDRESS_WIDTH:0]   delay_ext;

    // A delay change takes effect in the cycle it is seen: the read decision
    // for that cycle already uses the new delay, which is never primed yet.
    assign delay_change = (delay != delay_q);

    assign rd_go    = en && (state == RUN) && !delay_change && (delay_q != '0);
    // Delay 0 would read the address being written this cycle; the RAM returns
    // the old word on such a collision, so the sample is bypassed instead.
    assign byp_load = en && (state == RUN) && !delay_change && (delay_q == '0);

    assign ram_wr_en   = en && !rst;
    assign ram_wr_addr = wr_ptr;
    assign ram_din     = din;
    assign ram_rd_en   = rd_go && !rst;
    assign ram_rd_addr = wr_ptr - delay_q;   // wraps modulo buffer depth

    assign dout   = sel_q ? ram_dout : byp_q;
    assign primed = (state == RUN);

    // Comparisons are done one bit wider so fill+1 cannot wrap past delay_q.
    assign fill_ext     = {1'b0, fill};
    assign fill_inc_ext = fill_ext + (ADDRESS_WIDTH + 1)'(1);
    assign delay_ext    = {1'b0, delay_q};

    always_comb begin
        state_next = state;
        fill_next  = fill;
        if (delay_change) begin
            // The strobe of this cycle is already in the buffer, so it counts.
            state_next = PRIME;
            fill_next  = en ? ADDRESS_WIDTH'(1) : '0;
        end else if (state == PRIME) begin
            if (en) begin
                fill_next = fill + ADDRESS_WIDTH'(1);
            end
            if ((delay_q == '0) || (fill_ext >= delay_ext) ||
                (en && (fill_inc_ext >= delay_ext))) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIME;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill       <= '0;
            delay_q    <= '0;
            sel_q      <= 1'b0;
            byp_q      <= '0;
            dout_valid <= 1'b0;
        end else begin
            fill       <= fill_next;
            delay_q    <= delay;
            sel_q      <= rd_go;
            byp_q      <= byp_load ? din : '0;
            dout_valid <= en;
            if (en) begin
                wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
            end
        end
    end

endmodule
